// File: rtl/vco_adc_decimator.sv
// vco_adc_decimator: first-difference + sinc1 decimation of VCO phase snapshots into a FWFT FIFO
module vco_adc_decimator #(
    parameter int CNT_W      = 12,
    parameter int OUT_W      = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clear,
    input  logic [15:0]                   osr,
    input  logic                          phase_valid,
    input  logic [CNT_W-1:0]              phase_cnt,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          ovf,
    output logic                          sat
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, ACCUM} state_t;

    state_t           state;
    logic [CNT_W-1:0] prev, diff;
    logic [OUT_W-1:0] acc, sum;
    logic [OUT_W:0]   wide;
    logic [15:0]      cnt, osr_q, osr_eff;
    logic             sat_hit, last, push, pop, full, wr;
    logic [AW-1:0]    wp, rp;
    logic [OUT_W-1:0] mem [FIFO_DEPTH];

    // Wrapping difference, saturating sum and FIFO handshake decisions
    always_comb begin
        diff      = phase_cnt - prev;
        wide      = {1'b0, acc} + {{(OUT_W + 1 - CNT_W){1'b0}}, diff};
        sat_hit   = wide[OUT_W];
        sum       = sat_hit ? '1 : wide[OUT_W-1:0];
        last      = cnt == osr_q - 16'd1;
        osr_eff   = (osr == 16'd0) ? 16'd1 : osr;
        push      = en && !clear && phase_valid && state == ACCUM && last;
        out_valid = fifo_level != '0;
        pop       = out_valid && out_ready && !clear;
        full      = fifo_level == (AW + 1)'(FIFO_DEPTH);
        wr        = push && (!full || pop);
        out_data  = out_valid ? mem[rp] : '0;
        busy      = state == ACCUM;
    end

    // Control FSM: prime on the first snapshot, then accumulate windows of osr_q diffs
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prev  <= '0;
            acc   <= '0;
            cnt   <= '0;
            osr_q <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            state <= en ? PRIME : IDLE;
            if (en) osr_q <= osr_eff;
        end else if (!en) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state <= PRIME;
                    osr_q <= osr_eff;
                end
                PRIME: if (phase_valid) begin
                    prev  <= phase_cnt;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ACCUM;
                end
                ACCUM: if (phase_valid) begin
                    prev <= phase_cnt;
                    acc  <= last ? '0 : sum;
                    cnt  <= last ? '0 : cnt + 16'd1;
                    if (sat_hit) sat <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
        end else if (clear) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            if (push && full && !pop) ovf <= 1'b1;
            fifo_level <= fifo_level + (AW + 1)'(wr) - (AW + 1)'(pop);
        end
    end

    // FIFO storage; the head is read combinationally from these registers
    always_ff @(posedge wb_clk_i) begin
        if (wr) mem[wp] <= sum;
    end
endmodule

// File: tb/tb_vco_adc_decimator.sv
// tb_vco_adc_decimator: directed and randomized checks of the VCO ADC decimator
module tb_vco_adc_decimator;
    logic        wb_clk_i = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, clear = 1'b0, phase_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] osr = 16'd1;
    logic [11:0] phase_cnt = '0;
    logic [23:0] out_data;
    logic        out_valid, busy, ovf, sat;
    logic [3:0]  fifo_level;
    int          total = 0, bad = 0;

    vco_adc_decimator #(.CNT_W(12), .OUT_W(24), .FIFO_DEPTH(8)) dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n), .en(en), .clear(clear), .osr(osr),
        .phase_valid(phase_valid), .phase_cnt(phase_cnt), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
        .busy(busy), .ovf(ovf), .sat(sat)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic strobe(input logic [11:0] v);
        phase_valid = 1'b1;
        phase_cnt   = v;
        tick();
        phase_valid = 1'b0;
    endtask

    task automatic restart(input logic [15:0] n);
        en = 1'b0;
        tick();
        osr = n;
        en  = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 24'd0) begin bad++; $display("FAIL reset_data: got %0h want 0", out_data); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if ({busy, ovf, sat} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, ovf, sat}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        restart(16'd4);
        strobe(12'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        strobe(12'd10);
        strobe(12'd25);
        strobe(12'd40);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got %b want 0", out_valid); end
        strobe(12'd60);
        total++; if ({out_valid, out_data} !== {1'b1, 24'd60}) begin bad++; $display("FAIL basic_word: got %b/%0d want 1/60", out_valid, out_data); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL basic_level: got %0d want 1", fifo_level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pop: got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        restart(16'd1);
        strobe(12'd4090);
        strobe(12'd5);
        strobe(12'd20);
        total++; if (fifo_level !== 4'd2) begin bad++; $display("FAIL wrap_level: got %0d want 2", fifo_level); end
        total++; if (out_data !== 24'd11) begin bad++; $display("FAIL wrap_first: got %0d want 11", out_data); end
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== 24'd15) begin bad++; $display("FAIL wrap_second: got %0d want 15", out_data); end
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_fifo_full();
        restart(16'd1);
        for (int i = 0; i < 10; i++) strobe(12'(i));
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL full_level: got %0d want 8", fifo_level); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL full_ovf: got %b want 1", ovf); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if ({out_valid, out_data} !== {1'b1, 24'd1}) begin bad++; $display("FAIL full_drain%0d: got %b/%0d want 1/1", i, out_valid, out_data); end
            tick();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", out_valid); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL full_ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_back_to_back();
        int q[$];
        int d;
        logic [11:0] v;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if ({ovf, fifo_level} !== {1'b0, 4'd0}) begin bad++; $display("FAIL b2b_clear: got %b/%0d want 0/0", ovf, fifo_level); end
        v = 12'($urandom);
        strobe(v);
        for (int i = 0; i < 8; i++) begin
            d = $urandom_range(1, 4095);
            v = v + 12'(d);
            strobe(v);
            q.push_back(d);
        end
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL b2b_fill: got %0d want 8", fifo_level); end
        d = $urandom_range(1, 4095);
        v = v + 12'(d);
        phase_valid = 1'b1;
        phase_cnt   = v;
        out_ready   = 1'b1;
        tick();
        phase_valid = 1'b0;
        out_ready   = 1'b0;
        void'(q.pop_front());
        q.push_back(d);
        total++; if ({ovf, fifo_level} !== {1'b0, 4'd8}) begin bad++; $display("FAIL b2b_level: got %b/%0d want 0/8", ovf, fifo_level); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (out_data !== 24'(q[i])) begin bad++; $display("FAIL b2b_word%0d: got %0d want %0d", i, out_data, q[i]); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_enable_drop();
        restart(16'd4);
        strobe(12'd0);
        strobe(12'd7);
        strobe(12'd9);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy: got %b want 1", busy); end
        en = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle: got %b want 0", busy); end
        en = 1'b1;
        tick();
        for (int i = 100; i <= 104; i++) strobe(12'(i));
        total++; if ({fifo_level, out_data} !== {4'd1, 24'd4}) begin bad++; $display("FAIL drop_word: got %0d/%0d want 1/4", fifo_level, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int s[$];
        int exp[$];
        int n, ne, words, sum, idx, got, cyc;
        logic pv;
        for (int it = 0; it < 8; it++) begin
            s.delete();
            exp.delete();
            n     = $urandom_range(0, 5);
            ne    = (n == 0) ? 1 : n;
            words = $urandom_range(1, 6);
            for (int k = 0; k <= ne * words; k++) s.push_back($urandom_range(0, 4095));
            for (int w = 0; w < words; w++) begin
                sum = 0;
                for (int j = 0; j < ne; j++) sum += (s[w * ne + j + 1] - s[w * ne + j] + 4096) % 4096;
                exp.push_back(sum);
            end
            restart(16'(n));
            idx = 0;
            got = 0;
            cyc = 0;
            while (idx < s.size() && cyc < 1000) begin
                pv          = $urandom_range(0, 3) != 0;
                phase_valid = pv;
                if (pv) phase_cnt = 12'(s[idx]);
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    total++;
                    if (got >= exp.size()) begin bad++; $display("FAIL rand_extra: got %0d want none", out_data); end
                    else if (out_data !== 24'(exp[got])) begin bad++; $display("FAIL rand_word: got %0d want %0d", out_data, exp[got]); end
                    got++;
                end
                tick();
                if (pv) idx++;
                cyc++;
            end
            phase_valid = 1'b0;
            out_ready   = 1'b1;
            for (int c = 0; c < 20; c++) begin
                if (out_valid) begin
                    total++;
                    if (got >= exp.size()) begin bad++; $display("FAIL rand_extra: got %0d want none", out_data); end
                    else if (out_data !== 24'(exp[got])) begin bad++; $display("FAIL rand_word: got %0d want %0d", out_data, exp[got]); end
                    got++;
                end
                tick();
            end
            out_ready = 1'b0;
            total++; if (got != exp.size() || idx != s.size()) begin bad++; $display("FAIL rand_count: got %0d words want %0d", got, exp.size()); end
        end
    endtask

    task automatic test_saturation();
        logic [11:0] v;
        restart(16'd4100);
        v = '0;
        phase_valid = 1'b1;
        for (int i = 0; i <= 4100; i++) begin
            phase_cnt = v;
            tick();
            v = v - 12'd1;
        end
        phase_valid = 1'b0;
        total++; if ({fifo_level, out_data} !== {4'd1, 24'hFFFFFF}) begin bad++; $display("FAIL sat_word: got %0d/%0h want 1/ffffff", fifo_level, out_data); end
        total++; if (sat !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", sat); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if ({fifo_level, sat, busy, out_valid} !== {4'd0, 3'b000}) begin bad++; $display("FAIL sat_clear: got %0d/%b/%b/%b want 0/0/0/0", fifo_level, sat, busy, out_valid); end
        strobe(12'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sat_prime: got %b want 1", busy); end
    endtask

    task automatic test_reset_mid();
        restart(16'd1);
        strobe(12'd0);
        strobe(12'd3);
        strobe(12'd4000);
        @(negedge wb_clk_i);
        rst_n = 1'b0;
        #1;
        total++; if ({out_valid, busy, ovf, sat} !== 4'b0000) begin bad++; $display("FAIL rmid_flags: got %b want 0000", {out_valid, busy, ovf, sat}); end
        total++; if ({fifo_level, out_data} !== 28'd0) begin bad++; $display("FAIL rmid_fifo: got %0d/%0d want 0/0", fifo_level, out_data); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_fifo_full();
        test_back_to_back();
        test_enable_drop();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vco_adc_decimator.md
Name: vco_adc_decimator

Overview:
- Sits between a VCO ADC phase counter and the Wishbone-facing VCO ADC wrapper.
- Turns the free-running, wrapping VCO edge-count snapshots into frequency samples by first difference, then sums N samples (sinc1 decimation, N = OSR).
- Buffers the decimated words in a small first-word-fall-through FIFO, which the wrapper drains with a valid/ready handshake.

Parameters:
- CNT_W, 12: width of the VCO phase counter snapshot.
- OUT_W, 24: width of a decimated output word.
- FIFO_DEPTH, 8: number of output FIFO entries; must be a power of two, at least 2.

Ports:
- wb_clk_i  in  1  single system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enable; low forces IDLE.
- clear  in  1  synchronous flush, one-cycle pulse.
- osr  in  16  decimation ratio N; 0 is treated as 1.
- phase_valid  in  1  strobe: phase_cnt carries a new snapshot this cycle.
- phase_cnt  in  CNT_W  VCO edge-count snapshot, already synchronised, wraps modulo 2^CNT_W.
- out_data  out  OUT_W  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- busy  out  1  high while in ACCUM.
- ovf  out  1  sticky: a word was dropped because the FIFO was full.
- sat  out  1  sticky: the accumulator saturated.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; accumulator, sample count, prev, osr_q and FIFO pointers = 0. Outputs out_data=0, out_valid=0, fifo_level=0, busy=0, ovf=0, sat=0.
- FSM state IDLE: leave to PRIME when en=1.
- FSM state PRIME: osr_q is loaded on entry, as max(osr,1). On phase_valid: prev<=phase_cnt, acc<=0, cnt<=0, go to ACCUM. No word is produced in PRIME.
- FSM state ACCUM, on each phase_valid:
  - diff = (phase_cnt - prev) mod 2^CNT_W, unsigned; then prev<=phase_cnt.
  - sum = acc + diff, saturating at 2^OUT_W-1; saturation sets sat.
  - If cnt == osr_q-1: push sum into the FIFO, then acc<=0 and cnt<=0. Otherwise acc<=sum and cnt<=cnt+1.
- en=0 in any state: go to IDLE next edge. The partial accumulation is discarded; FIFO contents and flags are kept.
- Re-enabling always passes through PRIME; the first snapshot after PRIME is never differenced.
- Changes to osr outside PRIME are ignored until the next PRIME.
- Latency: the word is written on the edge that samples the final phase_valid. out_valid/out_data reflect it the following cycle if the FIFO was empty.
- FIFO pop: on out_valid && out_ready. out_data always shows the head entry combinationally from registered storage.
- FIFO push while full and no pop: the word is dropped, ovf<=1, level unchanged.
- FIFO push while full with a simultaneous pop: the pop occurs and the push is accepted; level stays at FIFO_DEPTH; ovf is not set.
- Push and pop on an empty FIFO: out_valid is 0, so no pop occurs; the push is accepted.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is never more than FIFO_DEPTH.
- clear has the highest priority over push, pop and the FSM:
  - Empties the FIFO and zeroes acc, cnt, ovf and sat.
  - Next state is PRIME if en=1, else IDLE.
  - A phase_valid in the same cycle is ignored.
- phase_valid outside PRIME/ACCUM is ignored.
- busy = (state==ACCUM).

Test Plan:
1. Basic decimation: osr=4, en=1, snapshots 0,10,25,40,60 -> exactly one word of 60. out_valid rises one cycle after the 5th strobe; busy=1 from the 2nd strobe onward.
2. Wrap-around: osr=1, snapshots 4090,5,20 -> words 11 then 15, in that order.
3. FIFO full: osr=1, out_ready=0, 10 snapshots 0..9 -> 9 diffs; fifo_level=8, ovf=1. Then raising out_ready pops eight words of 1; out_valid falls once the last word is popped.
4. Simultaneous push/pop at full: FIFO holds 8 entries; out_ready=1 in the same cycle as the completing strobe -> level stays 8, ovf=0, and the new word becomes the last entry.
5. Enable drop: osr=4; deassert en after 2 diffs; re-enable with snapshots 100,101,102,103,104 -> only one word of 4. Partial sums are not carried over; busy falls the cycle after en drops.
6. Saturation, clear and reset:
   - osr=4100 with every diff 4095 -> word 0xFFFFFF, sat=1.
   - A clear pulse then gives fifo_level=0, sat=0, state PRIME.
   - rst_n asserted mid-window clears all outputs immediately, without waiting for a clock edge.
